// File: rtl/dramctl.sv
// Single-bank FPM DRAM controller for a 68030-style bus: RAS/CAS sequencing,
// byte-lane write strobes, and CAS-before-RAS refresh with a pending counter.
module dramctl #(
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned PRECHARGE_CLKS = 3,
  parameter int unsigned REF_RAS_CLKS   = 4
) (
  input  logic        DRAM_CLK,
  input  logic        nRST,
  input  logic        nDRAMSEL,
  input  logic        nAS,
  input  logic        nDS,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [27:0] ADDR,
  output logic [12:0] MA,
  output logic        nRAS,
  output logic [3:0]  nCAS,
  output logic        nWE,
  output logic [1:0]  DSACK
);

  localparam int unsigned RCW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int unsigned CW  = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ROW    = 4'd1,
    ST_RCD    = 4'd2,
    ST_COL    = 4'd3,
    ST_CAS    = 4'd4,
    ST_HOLD   = 4'd5,
    ST_PRE    = 4'd6,
    ST_RF_CAS = 4'd7,
    ST_RF_RAS = 4'd8
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [12:0]     r_ma, w_ma_nxt;
  logic            r_nras, w_nras_nxt;
  logic [3:0]      r_ncas, w_ncas_nxt;
  logic            r_nwe, w_nwe_nxt;
  logic [1:0]      r_ack, w_ack_nxt;
  logic [RCW-1:0]  r_ref_cnt, w_ref_cnt_nxt;
  logic [1:0]      r_ref_pend, w_ref_pend_nxt;
  logic            w_wrap, w_ref_req, w_ref_done, w_busy;

  // Active-low lane strobes for offsets off..min(off+n-1,3); nCAS[3] is offset 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] siz);
    logic [2:0] last;
    logic [3:0] m;
    last = {1'b0, off} + ((siz == 2'b00) ? 3'd3 : ({1'b0, siz} - 3'd1));
    m = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      m[2'(3 - i)] = ~((3'(i) >= {1'b0, off}) && (3'(i) <= last));
    end
    return m;
  endfunction

  assign MA    = r_ma;
  assign nRAS  = r_nras;
  assign nCAS  = r_ncas;
  assign nWE   = r_nwe;
  assign DSACK = r_ack & {2{~nDS}};

  assign w_wrap        = (r_ref_cnt == RCW'(REFRESH_PERIOD - 1));
  assign w_ref_cnt_nxt = w_wrap ? RCW'(0) : (r_ref_cnt + RCW'(1));
  // A wrap on the same edge as the IDLE check still counts as pending.
  assign w_ref_req     = (r_ref_pend != 2'd0) || w_wrap;
  assign w_busy        = r_state inside {ST_ROW, ST_RCD, ST_COL, ST_CAS, ST_HOLD};

  // Pending-refresh bookkeeping: increment on wrap, decrement on completion.
  always_comb begin
    w_ref_pend_nxt = r_ref_pend;
    case ({w_wrap, w_ref_done})
      2'b10:   w_ref_pend_nxt = (r_ref_pend == 2'd3) ? 2'd3 : (r_ref_pend + 2'd1);
      2'b01:   w_ref_pend_nxt = r_ref_pend - 2'd1;
      default: w_ref_pend_nxt = r_ref_pend;
    endcase
  end

  // Next-state and next-output logic for the access/refresh sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ma_nxt    = r_ma;
    w_nras_nxt  = r_nras;
    w_ncas_nxt  = r_ncas;
    w_nwe_nxt   = r_nwe;
    w_ack_nxt   = r_ack;
    w_ref_done  = 1'b0;
    if (w_busy && nAS) begin
      // Normal end of cycle from HOLD, or abort from any earlier access state.
      w_state_nxt = ST_PRE;
      w_cnt_nxt   = CW'(0);
      w_nras_nxt  = 1'b1;
      w_ncas_nxt  = 4'b1111;
      w_nwe_nxt   = 1'b1;
      w_ack_nxt   = 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ref_req) begin
            w_state_nxt = ST_RF_CAS;
            w_cnt_nxt   = CW'(0);
          end else if (!nDRAMSEL && !nAS) begin
            w_ma_nxt    = ADDR[27:15];
            w_nwe_nxt   = RnW;
            w_state_nxt = ST_ROW;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ROW: begin
          w_nras_nxt  = 1'b0;
          w_state_nxt = ST_RCD;
        end
        ST_RCD: begin
          w_ma_nxt    = ADDR[14:2];
          w_state_nxt = ST_COL;
        end
        ST_COL: begin
          if (RnW || !nDS) begin
            w_ncas_nxt  = RnW ? 4'b0000 : lane_mask(ADDR[1:0], SIZ);
            w_cnt_nxt   = CW'(0);
            w_state_nxt = ST_CAS;
          end else begin
            w_state_nxt = ST_COL;
          end
        end
        ST_CAS: begin
          if (r_cnt == CW'(1)) begin
            w_ack_nxt   = 2'b11;
            w_cnt_nxt   = CW'(0);
            w_state_nxt = ST_HOLD;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        ST_HOLD: w_state_nxt = ST_HOLD;
        ST_PRE: begin
          if (r_cnt >= CW'(PRECHARGE_CLKS - 1)) begin
            w_cnt_nxt   = CW'(0);
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        ST_RF_CAS: begin
          w_ncas_nxt  = 4'b0000;
          w_cnt_nxt   = CW'(0);
          w_state_nxt = ST_RF_RAS;
        end
        ST_RF_RAS: begin
          if (r_cnt >= CW'(REF_RAS_CLKS)) begin
            w_nras_nxt  = 1'b1;
            w_ncas_nxt  = 4'b1111;
            w_ref_done  = 1'b1;
            w_cnt_nxt   = CW'(0);
            w_state_nxt = ST_PRE;
          end else begin
            w_nras_nxt  = 1'b0;
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CW'(0);
          w_nras_nxt  = 1'b1;
          w_ncas_nxt  = 4'b1111;
          w_nwe_nxt   = 1'b1;
          w_ack_nxt   = 2'b00;
        end
      endcase
    end
  end

  // State, output and refresh-timer registers with synchronous active-low reset.
  always_ff @(posedge DRAM_CLK) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= CW'(0);
      r_ma       <= 13'd0;
      r_nras     <= 1'b1;
      r_ncas     <= 4'b1111;
      r_nwe      <= 1'b1;
      r_ack      <= 2'b00;
      r_ref_cnt  <= RCW'(0);
      r_ref_pend <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ma       <= w_ma_nxt;
      r_nras     <= w_nras_nxt;
      r_ncas     <= w_ncas_nxt;
      r_nwe      <= w_nwe_nxt;
      r_ack      <= w_ack_nxt;
      r_ref_cnt  <= w_ref_cnt_nxt;
      r_ref_pend <= w_ref_pend_nxt;
    end
  end

endmodule

// File: tb/tb_dramctl.sv
// Scenario bench for dramctl: each task scripts bus stimulus cycle by cycle and
// queues the expected pin state, which is popped and compared after each edge.
module tb_dramctl;

  localparam int P = 60;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        ndramsel = 1'b1;
  logic        nas = 1'b1;
  logic        nds = 1'b1;
  logic        rnw = 1'b1;
  logic [1:0]  siz = 2'b00;
  logic [27:0] addr = 28'd0;
  logic [12:0] ma;
  logic        nras;
  logic [3:0]  ncas;
  logic        nwe;
  logic [1:0]  dsack;

  always #5 clk = ~clk;

  dramctl #(.REFRESH_PERIOD(P), .PRECHARGE_CLKS(3), .REF_RAS_CLKS(4)) dut (
    .DRAM_CLK(clk), .nRST(nrst), .nDRAMSEL(ndramsel), .nAS(nas), .nDS(nds),
    .RnW(rnw), .SIZ(siz), .ADDR(addr), .MA(ma), .nRAS(nras), .nCAS(ncas),
    .nWE(nwe), .DSACK(dsack)
  );

  typedef struct {
    string       nm;
    logic [20:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [12:0] e_ma;
  logic        e_nras;
  logic [3:0]  e_ncas;
  logic        e_nwe;
  logic [1:0]  e_ds;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [20:0] obs();
    return {ma, nras, ncas, nwe, dsack};
  endfunction

  task automatic push(input string nm);
    exp_t x;
    x.nm  = nm;
    x.val = {e_ma, e_nras, e_ncas, e_nwe, e_ds};
    sbq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ndramsel = 1'b1; nas = 1'b1; nds = 1'b1; rnw = 1'b1; siz = 2'b00; addr = 28'd0;
  endtask

  task automatic exp_reset_vals();
    e_ma = 13'd0; e_nras = 1'b1; e_ncas = 4'b1111; e_nwe = 1'b1; e_ds = 2'b00;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    bus_idle();
    tick();
    nrst = 1'b1;
    exp_reset_vals();
  endtask

  task automatic exp_close();
    e_nras = 1'b1; e_ncas = 4'b1111; e_nwe = 1'b1; e_ds = 2'b00;
  endtask

  task automatic test_reset();
    exp_t x;
    nrst = 1'b0; ndramsel = 1'b0; nas = 1'b0; nds = 1'b0; rnw = 1'b0;
    addr = 28'h1234568;
    exp_reset_vals();
    for (int c = 0; c < 4; c++) begin
      push($sformatf("reset_hold_c%0d", c));
      tick();
      x = sbq.pop_front();
      n_tests++;
      if (obs() !== x.val) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
      end
    end
    bus_idle();
    nrst = 1'b1;
  endtask

  task automatic test_read();
    exp_t x;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      case (c)
        0:  begin ndramsel = 1'b0; nas = 1'b0; nds = 1'b0; rnw = 1'b1; addr = 28'h1234568;
                  e_ma = 13'h0246; e_nwe = 1'b1; end
        1:  e_nras = 1'b0;
        2:  e_ma = 13'h115A;
        3:  e_ncas = 4'b0000;
        5:  e_ds = 2'b11;
        6:  begin nds = 1'b1; e_ds = 2'b00; end
        7:  begin nds = 1'b0; e_ds = 2'b11; end
        8:  begin nas = 1'b1; nds = 1'b1; ndramsel = 1'b1; exp_close(); end
        9:  begin ndramsel = 1'b0; nas = 1'b0; rnw = 1'b0; addr = 28'h0ABCDEF; end
        12: begin e_ma = 13'h0157; e_nwe = 1'b0; end
        13: e_nras = 1'b0;
        default: ;
      endcase
      push($sformatf("read_c%0d", c));
      tick();
      x = sbq.pop_front();
      n_tests++;
      if (obs() !== x.val) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
      end
    end
  endtask

  task automatic test_write_byte();
    exp_t x;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      case (c)
        0:  begin ndramsel = 1'b0; nas = 1'b0; nds = 1'b1; rnw = 1'b0; siz = 2'b01;
                  addr = 28'h0C0FFEE; e_ma = 13'h0181; e_nwe = 1'b0; end
        1:  e_nras = 1'b0;
        2:  e_ma = 13'h1FFB;
        6:  begin nds = 1'b0; e_ncas = 4'b1101; end
        8:  e_ds = 2'b11;
        9:  begin nas = 1'b1; nds = 1'b1; ndramsel = 1'b1; exp_close(); end
        default: ;
      endcase
      push($sformatf("wbyte_c%0d", c));
      tick();
      x = sbq.pop_front();
      n_tests++;
      if (obs() !== x.val) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
      end
    end
  endtask

  task automatic test_lanes();
    exp_t       x;
    logic [1:0] t_siz [6];
    logic [1:0] t_off [6];
    logic [3:0] t_mask [6];
    t_siz  = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11};
    t_off  = '{2'd3, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
    t_mask = '{4'b1110, 4'b1000, 4'b0000, 4'b0111, 4'b1100, 4'b1100};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int c = 0; c <= 6; c++) begin
        case (c)
          0: begin ndramsel = 1'b0; nas = 1'b0; nds = 1'b0; rnw = 1'b0; siz = t_siz[i];
                   addr = 28'h4000000 | {26'd0, t_off[i]}; e_ma = 13'h0800; e_nwe = 1'b0; end
          1: e_nras = 1'b0;
          2: e_ma = 13'h0000;
          3: e_ncas = t_mask[i];
          5: e_ds = 2'b11;
          6: begin nas = 1'b1; nds = 1'b1; ndramsel = 1'b1; exp_close(); end
          default: ;
        endcase
        push($sformatf("lanes_siz%b_off%0d_c%0d", t_siz[i], t_off[i], c));
        tick();
        x = sbq.pop_front();
        n_tests++;
        if (obs() !== x.val) begin
          n_fail++;
          $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
        end
      end
    end
  endtask

  task automatic test_abort();
    exp_t x;
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      case (c)
        0: begin ndramsel = 1'b0; nas = 1'b0; nds = 1'b0; rnw = 1'b1; addr = 28'h1234568;
                 e_ma = 13'h0246; e_nwe = 1'b1; end
        1: e_nras = 1'b0;
        2: e_ma = 13'h115A;
        3: e_ncas = 4'b0000;
        4: begin nas = 1'b1; ndramsel = 1'b1; exp_close(); end
        default: ;
      endcase
      push($sformatf("abort_c%0d", c));
      tick();
      x = sbq.pop_front();
      n_tests++;
      if (obs() !== x.val) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
      end
    end
  endtask

  task automatic test_refresh_priority();
    exp_t x;
    do_reset();
    for (int k = 1; k <= P + 16; k++) begin
      case (k)
        P:      begin ndramsel = 1'b0; nas = 1'b0; nds = 1'b0; rnw = 1'b1; addr = 28'h1234568; end
        P + 1:  e_ncas = 4'b0000;
        P + 2:  e_nras = 1'b0;
        P + 6:  begin e_nras = 1'b1; e_ncas = 4'b1111; end
        P + 10: begin e_ma = 13'h0246; e_nwe = 1'b1; end
        P + 11: e_nras = 1'b0;
        P + 12: e_ma = 13'h115A;
        P + 13: e_ncas = 4'b0000;
        P + 15: e_ds = 2'b11;
        default: ;
      endcase
      push($sformatf("refresh_k%0d", k));
      tick();
      x = sbq.pop_front();
      n_tests++;
      if (obs() !== x.val) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    // Reset while the bus cycle sits in HOLD with DSACK asserted.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      case (c)
        0: begin ndramsel = 1'b0; nas = 1'b0; nds = 1'b0; rnw = 1'b1; addr = 28'h1234568;
                 e_ma = 13'h0246; e_nwe = 1'b1; end
        1: e_nras = 1'b0;
        2: e_ma = 13'h115A;
        3: e_ncas = 4'b0000;
        5: e_ds = 2'b11;
        6: begin nrst = 1'b0; exp_reset_vals(); end
        8: begin nrst = 1'b1; bus_idle(); end
        default: ;
      endcase
      push($sformatf("rst_hold_c%0d", c));
      tick();
      x = sbq.pop_front();
      n_tests++;
      if (obs() !== x.val) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
      end
    end
    // Reset during RF_RAS; afterwards the next refresh must wait a full period.
    do_reset();
    for (int k = 1; k <= P + 4; k++) begin
      case (k)
        P + 1: e_ncas = 4'b0000;
        P + 2: e_nras = 1'b0;
        P + 4: begin nrst = 1'b0; nds = 1'b0; exp_reset_vals(); end
        default: ;
      endcase
      push($sformatf("rst_rfras_k%0d", k));
      tick();
      x = sbq.pop_front();
      n_tests++;
      if (obs() !== x.val) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
      end
    end
    for (int k = 1; k <= P + 1; k++) begin
      case (k)
        1:     begin nrst = 1'b1; nds = 1'b1; end
        P + 1: e_ncas = 4'b0000;
        default: ;
      endcase
      push($sformatf("post_rst_k%0d", k));
      tick();
      x = sbq.pop_front();
      n_tests++;
      if (obs() !== x.val) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (ma|nras|ncas|nwe|dsack)", x.nm, obs(), x.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_byte();
    test_lanes();
    test_abort();
    test_refresh_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
